excess_3_to_bcd_serial: RTL and testbench

Bit-serial Excess-3 to BCD decoder. It is the receive-side counterpart of the serial BCD-to-Excess-3 encoder: it consumes 4-bit Excess-3 code words LSB-first on a single wire and emits the BCD digit serially with zero latency (Mealy output). It also presents the completed digit in parallel with a one-cycle valid strobe, and it flags the six illegal Excess-3 codes. It sits downstream of the encoder's serial output, or of any serial link carrying Excess-3 digits.

---
 rtl/excess_3_to_bcd_serial.sv | 192 +++++++++++++++++++
 tb/tb_excess_3_to_bcd_serial.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/excess_3_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// excess_3_to_bcd_serial
//
// Bit-serial Excess-3 to BCD decoder. Excess-3 code words arrive LSB first on
// B_in, and the circuit subtracts 4'b0011 one bit at a time with a borrow. The
// serial BCD result leaves on B_out in the same cycle (Mealy output). When bit 3
// is consumed, the whole digit is also shown in parallel with a one-cycle valid
// strobe and an illegal-code flag.
//
// All registers update on the falling edge of clk. This matches the bit timing
// of the serial BCD-to-Excess-3 encoder that feeds this block.
//
// Ports
//   clk          in   1  clock; state updates on the falling edge
//   reset_b      in   1  asynchronous active-low reset
//   B_in         in   1  serial Excess-3 bit, LSB first
//   en           in   1  bit valid; B_in is consumed only when en=1
//   sync         in   1  with en=1, the current bit is bit 0 of a new word
//   clr_err      in   1  synchronous clear of err_sticky (a new error wins)
//   B_out        out  1  serial BCD bit, combinational, forced to 0 when en=0
//   digit        out  4  last completed 4-bit difference
//   digit_valid  out  1  one-cycle pulse after bit 3 is consumed
//   code_err     out  1  qualifies digit_valid; 1 = illegal Excess-3 code
//   err_sticky   out  1  set by any code error, held until clr_err or reset
//   bit_pos      out  2  index of the next expected bit
// -----------------------------------------------------------------------------
module excess_3_to_bcd_serial (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       B_in,
  input  logic       en,
  input  logic       sync,
  input  logic       clr_err,
  output logic       B_out,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       code_err,
  output logic       err_sticky,
  output logic [1:0] bit_pos
);

  // Each state names a bit position and whether a borrow is pending into it.
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1_NB = 3'd1,
    S1_B  = 3'd2,
    S2_NB = 3'd3,
    S2_B  = 3'd4,
    S3_NB = 3'd5,
    S3_B  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  state_t     eff_state;
  state_t     nxt_state;
  logic [2:0] sr_q, sr_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       code_err_q, code_err_d;
  logic       sticky_q, sticky_d;

  logic       out_bit;
  logic       borrow;
  logic       last_bit;
  logic       done;
  logic       word_err;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S0;
      sr_q       <= 3'b000;
      digit_q    <= 4'h0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      sticky_q   <= sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial subtractor: output bit, borrow and successor state.
  // Bits 0 and 1 subtract a 1 from the constant 0011; bits 2 and 3 subtract
  // only the pending borrow.
  // ---------------------------------------------------------------------------
  always_comb begin
    // sync restarts the word. The discarded partial bits are pushed out of the
    // shift register by the three shifts that come before the next bit 3.
    eff_state = sync ? S0 : state_q;
    out_bit   = 1'b0;
    borrow    = 1'b0;
    nxt_state = S0;

    case (eff_state)
      S0: begin
        out_bit   = ~B_in;
        borrow    = ~B_in;
        nxt_state = B_in ? S1_NB : S1_B;
      end
      S1_NB: begin
        out_bit   = ~B_in;
        borrow    = ~B_in;
        nxt_state = B_in ? S2_NB : S2_B;
      end
      S1_B: begin
        // Subtracting 1 plus a borrow of 1 always leaves b and always borrows.
        out_bit   = B_in;
        borrow    = 1'b1;
        nxt_state = S2_B;
      end
      S2_NB: begin
        out_bit   = B_in;
        borrow    = 1'b0;
        nxt_state = S3_NB;
      end
      S2_B: begin
        out_bit   = ~B_in;
        borrow    = ~B_in;
        nxt_state = B_in ? S3_NB : S3_B;
      end
      S3_NB: begin
        out_bit   = B_in;
        borrow    = 1'b0;
        nxt_state = S0;
      end
      S3_B: begin
        out_bit   = ~B_in;
        borrow    = ~B_in;
        nxt_state = S0;
      end
      default: begin
        out_bit   = 1'b0;
        borrow    = 1'b0;
        nxt_state = S0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word assembly, validity, and error tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    last_bit = (eff_state == S3_NB) || (eff_state == S3_B);
    done     = en & last_bit;

    // A final borrow means the code was below 3. If out3 is set together with
    // bit 2 or bit 1, the difference is above 9.
    word_err = borrow | (out_bit & (sr_q[2] | sr_q[1]));

    state_d    = en ? nxt_state : state_q;
    sr_d       = en ? {out_bit, sr_q[2:1]} : sr_q;
    digit_d    = done ? {out_bit, sr_q} : digit_q;
    code_err_d = done ? word_err : code_err_q;
    valid_d    = done;

    // A new error takes priority over a clear in the same cycle.
    if (done && word_err) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    case (state_q)
      S1_NB, S1_B: bit_pos = 2'd1;
      S2_NB, S2_B: bit_pos = 2'd2;
      S3_NB, S3_B: bit_pos = 2'd3;
      default:     bit_pos = 2'd0;
    endcase
  end

  assign B_out       = en & out_bit;
  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign code_err    = code_err_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_excess_3_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// tb_excess_3_to_bcd_serial
//
// Directed bench for the serial Excess-3 to BCD decoder. Inputs are driven just
// after each rising edge. B_out is checked before the falling edge, and the
// registered outputs are checked just after it.
// -----------------------------------------------------------------------------
module tb_excess_3_to_bcd_serial;

  logic       clk;
  logic       reset_b;
  logic       B_in;
  logic       en;
  logic       sync;
  logic       clr_err;
  logic       B_out;
  logic [3:0] digit;
  logic       digit_valid;
  logic       code_err;
  logic       err_sticky;
  logic [1:0] bit_pos;

  int total = 0;
  int bad   = 0;

  excess_3_to_bcd_serial dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .B_in        (B_in),
    .en          (en),
    .sync        (sync),
    .clr_err     (clr_err),
    .B_out       (B_out),
    .digit       (digit),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .err_sticky  (err_sticky),
    .bit_pos     (bit_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic e, input logic s, input logic c);
    @(posedge clk);
    #1;
    B_in    = b;
    en      = e;
    sync    = s;
    clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Sends one 4-bit code LSB first and checks every bit and the resulting word.
  task automatic send_word(input string tag, input logic [3:0] code,
                           input logic [3:0] exp_d, input logic exp_e,
                           input logic s0, input logic c3, input logic exp_st);
    for (int i = 0; i < 4; i++) begin
      step(code[i], 1'b1, (i == 0) ? s0 : 1'b0, (i == 3) ? c3 : 1'b0);
      chk($sformatf("%s.bout%0d", tag, i), 4'(B_out), 4'(exp_d[i]));
      if (!(i == 0 && s0)) chk($sformatf("%s.pos%0d", tag, i), 4'(bit_pos), 4'(i));
      tick();
      chk($sformatf("%s.valid%0d", tag, i), 4'(digit_valid), (i == 3) ? 4'd1 : 4'd0);
    end
    chk({tag, ".digit"},  digit,           exp_d);
    chk({tag, ".err"},    4'(code_err),    4'(exp_e));
    chk({tag, ".sticky"}, 4'(err_sticky),  4'(exp_st));
  endtask

  initial begin
    logic [3:0] diff_tab [16];
    logic [15:0] err_tab;
    logic [3:0] gap_code;
    logic       st;

    // Expected difference (code - 3 mod 16) for each code 0..15.
    diff_tab = '{4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    // Illegal codes: 0,1,2 and 13,14,15.
    err_tab  = 16'b1110_0000_0000_0111;

    reset_b = 1'b0;
    B_in    = 1'b0;
    en      = 1'b1;
    sync    = 1'b0;
    clr_err = 1'b0;
    #3;
    chk("rst.pos",    4'(bit_pos),     4'd0);
    chk("rst.digit",  digit,           4'h0);
    chk("rst.valid",  4'(digit_valid), 4'd0);
    chk("rst.err",    4'(code_err),    4'd0);
    chk("rst.sticky", 4'(err_sticky),  4'd0);
    chk("rst.bout",   4'(B_out),       4'd1);
    en = 1'b0;
    #1;
    chk("rst.bout_en0", 4'(B_out), 4'd0);
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    tick();

    // Basic words and back-to-back words.
    send_word("w1010", 4'b1010, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("w0011", 4'b0011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("w1100", 4'b1100, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal codes. On the second one, clr_err is raised together with the new error.
    send_word("w0001", 4'b0001, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word("w1111", 4'b1111, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1);

    // Clear the sticky flag while idle.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("clr.sticky", 4'(err_sticky), 4'd0);
    chk("clr.digit",  digit,          4'hC);
    chk("clr.pos",    4'(bit_pos),    4'd0);

    // en gaps between bits.
    gap_code = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(gap_code[i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("gap.bout%0d", i), 4'(B_out), 4'(diff_tab[10][i]));
      tick();
      chk($sformatf("gap.valid%0d", i), 4'(digit_valid), (i == 3) ? 4'd1 : 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gap.bout_idle%0d", i), 4'(B_out), 4'd0);
      tick();
      chk($sformatf("gap.pos_idle%0d", i), 4'(bit_pos), 4'((i + 1) % 4));
      chk($sformatf("gap.valid_idle%0d", i), 4'(digit_valid), 4'd0);
    end
    chk("gap.digit", digit, 4'h7);
    chk("gap.err",   4'(code_err), 4'd0);

    // Partial word discarded by sync.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("part.pos",   4'(bit_pos),     4'd2);
    chk("part.valid", 4'(digit_valid), 4'd0);
    send_word("sync1011", 4'b1011, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);

    // Every code.
    st = 1'b0;
    for (int c = 0; c < 16; c++) begin
      st = st | err_tab[c];
      send_word($sformatf("ex%0d", c), 4'(c), diff_tab[c], err_tab[c], 1'b0, 1'b0, st);
    end

    // Reset in the middle of a word.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid.pos_before", 4'(bit_pos), 4'd2);
    B_in    = 1'b0;
    reset_b = 1'b0;
    #1;
    chk("mid.pos",    4'(bit_pos),     4'd0);
    chk("mid.digit",  digit,           4'h0);
    chk("mid.valid",  4'(digit_valid), 4'd0);
    chk("mid.err",    4'(code_err),    4'd0);
    chk("mid.sticky", 4'(err_sticky),  4'd0);
    chk("mid.bout",   4'(B_out),       4'd1);
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    en      = 1'b0;
    tick();
    send_word("post1010", 4'b1010, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
